serial_echo_ctrl: RTL and testbench
===================================

SERIAL_ECHO_CTRL -- requirements
Module: serial_echo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, the byte width of the rx_data and tx_data paths.
REQ-002 The block SHALL have parameter DEPTH, default 4, the echo FIFO depth in words; it SHALL be a power of 2 and at least 2.
REQ-003 The block SHALL have parameter MODE, default 1, the transform applied on pop: 0 = pass-through, 1 = invert all bits when the MSB is 1, 2 = always invert.
REQ-004 The block SHALL have parameter BUSY_TO, default 16, the maximum number of cycles to wait for the transmitter to go busy.
REQ-005 The block SHALL have port sys_clk, input, 1 bit: system clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port rx_data, input, DATA_W bits: received byte, valid while rx_status is 0.
REQ-008 The block SHALL have port rx_status, input, 1 bit: receiver status, active-low "byte ready".
REQ-009 The block SHALL have port tx_status, input, 1 bit: transmitter status, 1 = idle/ready, 0 = busy.
REQ-010 The block SHALL have port tx_data, output, DATA_W bits: byte to transmit, registered.
REQ-011 The block SHALL have port tx_enable, output, 1 bit: one-cycle transmit-start pulse, registered.
REQ-012 The block SHALL have port fifo_count, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag set when a received byte is dropped.

Function
REQ-014 The block SHALL register rx_status into rx_prev every cycle; a capture event SHALL be rx_status==0 && rx_prev==1, giving exactly one capture per falling edge.
REQ-015 On a capture event with the FIFO not full, the block SHALL write rx_data untransformed at that clock edge and increment fifo_count by 1.
REQ-016 On a capture event with the FIFO full, the block SHALL drop the byte, leave FIFO contents and fifo_count unchanged, and set overflow to 1.
REQ-017 The FIFO SHALL use circular read and write pointers that wrap from DEPTH-1 to 0.
REQ-018 On a simultaneous push and pop, both SHALL take effect and fifo_count SHALL be unchanged; a push when full together with a pop in the same cycle SHALL be accepted.
REQ-019 The FSM SHALL have states IDLE, SEND, WAIT_BUSY and WAIT_IDLE.
REQ-020 In IDLE, when fifo_count>0 and tx_status==1, the block SHALL pop one word, load tx_data with the MODE-transformed word, set tx_enable=1, and move to SEND.
REQ-021 In SEND, the block SHALL set tx_enable=0 and move to WAIT_BUSY, so tx_enable is exactly 1 cycle wide.
REQ-022 In WAIT_BUSY, the block SHALL move to WAIT_IDLE when tx_status==0, or return to IDLE after BUSY_TO cycles in the state with tx_status still 1 (the word is treated as sent, with no retry).
REQ-023 In WAIT_IDLE, the block SHALL return to IDLE when tx_status==1.
REQ-024 Latency: with the FIFO empty, the FSM in IDLE and tx_status==1, tx_enable SHALL be high in the 2nd cycle after the capture edge.
REQ-025 tx_data SHALL hold its last loaded value until the next pop.
REQ-026 With MODE=1, the transform SHALL be: if word[DATA_W-1]==1 then ~word, else word.
REQ-027 Captures SHALL continue in every FSM state; the FSM SHALL never block the receive path.

Reset
REQ-028 While reset is high, the block SHALL hold the FSM in IDLE and set both pointers to 0, fifo_count=0, tx_data=0, tx_enable=0, overflow=0 and rx_prev=0.
REQ-029 Because rx_prev resets to 0, an rx_status held low across reset release SHALL NOT produce a capture; a 1 then 0 sequence SHALL be required.
REQ-030 Reset asserted mid-transfer SHALL discard all FIFO contents and the in-flight word; no tx_enable pulse SHALL follow reset release until a new capture occurs.
REQ-031 overflow SHALL be cleared only by reset.

Verification
REQ-032 The bench SHALL check single echo: DATA_W=8, MODE=1, rx 0x41 with tx_status=1 -> tx_data=0x41 and one tx_enable pulse 2 cycles after the capture edge.
REQ-033 The bench SHALL check the MSB transform: MODE=1, rx 0xC3 -> tx_data=0x3C; MODE=2, rx 0x41 -> 0xBE; MODE=0, rx 0xC3 -> 0xC3.
REQ-034 The bench SHALL check burst and overflow: DEPTH=4, tx_status held 0, 5 captures 0x01..0x05 -> fifo_count=4 and overflow=1; after releasing tx_status, output order SHALL be 0x01..0x04, and 0x05 SHALL never appear.
REQ-035 The bench SHALL check the handshake: tx_status drops 3 cycles after the pulse and rises 20 cycles later -> the next tx_enable comes only after tx_status returns to 1; with tx_status never dropping, IDLE SHALL be re-entered after 16 cycles.
REQ-036 The bench SHALL check level hold: rx_status held low for 10 cycles -> exactly 1 capture, and fifo_count SHALL never exceed 1 before the pop.
REQ-037 The bench SHALL check reset mid-operation: 3 words queued, reset pulsed -> all outputs at reset values, fifo_count=0, and no tx_enable pulse afterwards.

Source files
------------

// File: rtl/serial_echo_ctrl.sv
// Echoes received bytes through a small FIFO to a transmitter; tx_enable rises 2 cycles after the capture edge.
// The receive path is never stalled: a byte that arrives while the FIFO is full is dropped and sets sticky overflow.
module serial_echo_ctrl #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int MODE    = 1,
    parameter int BUSY_TO = 16
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      rx_data,
    input  logic                   rx_status,
    input  logic                   tx_status,
    output logic [DATA_W-1:0]      tx_data,
    output logic                   tx_enable,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(BUSY_TO + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_IDLE} state_t;

    state_t              state_q, state_d;
    logic                rx_prev_q, rx_prev_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_enable_q, tx_enable_d;
    logic                overflow_q, overflow_d;
    logic [TO_W-1:0]     busy_cnt_q, busy_cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic capture, full, push, pop;

    function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] w);
        if (MODE == 0) return w;
        if (MODE == 1) return w[DATA_W-1] ? ~w : w;
        return ~w;
    endfunction

    always_comb begin
        rx_prev_d   = rx_status;
        capture     = !rx_status && rx_prev_q;
        full        = (count_q == CNT_W'(DEPTH));
        pop         = (state_q == IDLE) && (count_q != '0) && tx_status;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        push        = capture && (!full || pop);
        overflow_d  = overflow_q | (capture && full && !pop);
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;

        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_enable_d = 1'b0;
        busy_cnt_d  = '0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    tx_data_d   = xform(mem_q[rd_ptr_q]);
                    tx_enable_d = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                // A transmitter that never goes busy is assumed to have taken the word.
                if (!tx_status)                             state_d = WAIT_IDLE;
                else if (busy_cnt_q == TO_W'(BUSY_TO - 1))  state_d = IDLE;
                else                                        busy_cnt_d = busy_cnt_q + 1'b1;
            end
            WAIT_IDLE: if (tx_status) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rx_prev_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tx_data_q   <= '0;
            tx_enable_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rx_prev_q   <= rx_prev_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tx_data_q   <= tx_data_d;
            tx_enable_q <= tx_enable_d;
            overflow_q  <= overflow_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_data;
    end

    assign tx_data    = tx_data_q;
    assign tx_enable  = tx_enable_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_echo_ctrl.sv
// Bench for serial_echo_ctrl: three instances (MODE 0/1/2) share stimulus; a queue model predicts echoed words.
module tb_serial_echo_ctrl;
    localparam int DW      = 8;
    localparam int DEPTH   = 4;
    localparam int BUSY_TO = 16;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          sys_clk = 1'b0;
    logic          reset   = 1'b1;
    logic [DW-1:0] rx_data = '0;
    logic          rx_status = 1'b1;
    logic          tx_dir  = 1'b1;
    logic          tx_resp = 1'b1;
    logic          resp_en = 1'b0;
    logic          tx_status;
    assign tx_status = resp_en ? tx_resp : tx_dir;

    logic [DW-1:0] tx_data0, tx_data1, tx_data2;
    logic          tx_en0, tx_en1, tx_en2;
    logic [CW-1:0] cnt0, cnt1, cnt2;
    logic          ovf0, ovf1, ovf2;

    serial_echo_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .MODE(0), .BUSY_TO(BUSY_TO)) dut0 (
        .sys_clk(sys_clk), .reset(reset), .rx_data(rx_data), .rx_status(rx_status),
        .tx_status(tx_status), .tx_data(tx_data0), .tx_enable(tx_en0),
        .fifo_count(cnt0), .overflow(ovf0));
    serial_echo_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .MODE(1), .BUSY_TO(BUSY_TO)) dut1 (
        .sys_clk(sys_clk), .reset(reset), .rx_data(rx_data), .rx_status(rx_status),
        .tx_status(tx_status), .tx_data(tx_data1), .tx_enable(tx_en1),
        .fifo_count(cnt1), .overflow(ovf1));
    serial_echo_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .MODE(2), .BUSY_TO(BUSY_TO)) dut2 (
        .sys_clk(sys_clk), .reset(reset), .rx_data(rx_data), .rx_status(rx_status),
        .tx_status(tx_status), .tx_data(tx_data2), .tx_enable(tx_en2),
        .fifo_count(cnt2), .overflow(ovf2));

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc_cnt = 0;
    int            pulse_cnt = 0;
    int            last_pulse_cyc = 0;
    int            prev_pulse_cyc = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_w;
    logic          prev_en = 1'b0;

    initial forever #5 sys_clk = ~sys_clk;
    initial forever begin @(posedge sys_clk); cyc_cnt++; end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Echo rule from the behavioural view: mode 0 passes, 1 inverts words with MSB set, 2 always inverts.
    function automatic logic [DW-1:0] xf(input int mode, input logic [DW-1:0] w);
        if (mode == 0) return w;
        if (mode == 1) return w[DW-1] ? ~w : w;
        return ~w;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // One 1->0 transition on rx_status; the model keeps the byte unless DEPTH words are already waiting.
    task automatic send(input logic [DW-1:0] b);
        rx_data = b;
        rx_status = 1'b1;
        cyc(1);
        rx_status = 1'b0;
        cyc(1);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
    endtask

    task automatic wait_pulses(input int target, input int budget, input string tag);
        int i = 0;
        while (pulse_cnt < target && i < budget) begin
            cyc(1);
            i++;
        end
        chk(tag, 32'(pulse_cnt >= target), 32'd1);
    endtask

    // tx-side monitor: every pulse must match the oldest outstanding word, transformed per instance.
    initial forever begin
        @(negedge sys_clk);
        if (!reset && tx_en1) begin
            pulse_cnt++;
            prev_pulse_cyc = last_pulse_cyc;
            last_pulse_cyc = cyc_cnt;
            chk("pulse_width", 32'(prev_en), 32'd0);
            chk("en_mode0", 32'(tx_en0), 32'd1);
            chk("en_mode2", 32'(tx_en2), 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'(tx_data1), 32'hFFFF_FFFF);
            end else begin
                mon_w = exp_q.pop_front();
                chk("data_mode0", 32'(tx_data0), 32'(xf(0, mon_w)));
                chk("data_mode1", 32'(tx_data1), 32'(xf(1, mon_w)));
                chk("data_mode2", 32'(tx_data2), 32'(xf(2, mon_w)));
            end
        end
        prev_en = tx_en1;
    end

    initial begin
        int base;
        int raise_cyc;
        int max_cnt;
        int n;

        cyc(3);
        chk("rst_tx_data", 32'(tx_data1), 32'd0);
        chk("rst_tx_enable", 32'(tx_en1), 32'd0);
        chk("rst_fifo_count", 32'({cnt0, cnt1, cnt2}), 32'd0);
        chk("rst_overflow", 32'({ovf0, ovf1, ovf2}), 32'd0);
        reset = 1'b0;
        cyc(2);

        // Single echo and exact latency
        send(8'h41);
        @(negedge sys_clk);
        chk("lat_cycle1_low", 32'(tx_en1), 32'd0);
        @(negedge sys_clk);
        chk("lat_cycle2_high", 32'(tx_en1), 32'd1);
        chk("echo_41_mode1", 32'(tx_data1), 32'h41);
        chk("echo_41_mode2", 32'(tx_data2), 32'hBE);
        @(negedge sys_clk);
        chk("pulse_one_cycle", 32'(tx_en1), 32'd0);
        cyc(BUSY_TO + 4);
        chk("tx_data_hold", 32'(tx_data1), 32'h41);

        // MSB-dependent transform
        send(8'hC3);
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("echo_c3_mode1", 32'(tx_data1), 32'h3C);
        chk("echo_c3_mode0", 32'(tx_data0), 32'hC3);
        cyc(BUSY_TO + 4);

        // Transmitter never goes busy: second word waits out the full timeout
        base = pulse_cnt;
        send(8'h12);
        send(8'h34);
        wait_pulses(base + 2, 3 * BUSY_TO, "timeout_pulses");
        chk("timeout_gap", 32'(last_pulse_cyc - prev_pulse_cyc), 32'(BUSY_TO + 2));
        cyc(BUSY_TO + 4);

        // Busy handshake: drop 3 cycles after the pulse, rise 20 cycles later
        base = pulse_cnt;
        send(8'h55);
        send(8'h66);
        wait_pulses(base + 1, 10, "hs_first_pulse");
        cyc(2);
        tx_dir = 1'b0;
        base = pulse_cnt;
        cyc(20);
        chk("hs_no_pulse_busy", 32'(pulse_cnt), 32'(base));
        tx_dir = 1'b1;
        raise_cyc = cyc_cnt;
        wait_pulses(base + 1, 10, "hs_resume_pulse");
        chk("hs_resume_gap", 32'(last_pulse_cyc - raise_cyc), 32'd2);
        cyc(BUSY_TO + 4);

        // rx_status held low: exactly one capture
        tx_dir = 1'b0;
        base = pulse_cnt;
        send(8'h77);
        max_cnt = int'(cnt1);
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            if (int'(cnt1) > max_cnt) max_cnt = int'(cnt1);
        end
        chk("level_hold_count", 32'(cnt1), 32'd1);
        chk("level_hold_max", 32'(max_cnt), 32'd1);
        tx_dir = 1'b1;
        wait_pulses(base + 1, 10, "level_hold_pulse");
        cyc(BUSY_TO + 4);

        // Burst into a stalled transmitter: fifth byte dropped
        tx_dir = 1'b0;
        chk("ovf_before_burst", 32'(ovf1), 32'd0);
        for (int i = 1; i <= 5; i++) send(8'(i));
        chk("burst_fifo_count", 32'(cnt1), 32'(DEPTH));
        chk("burst_overflow", 32'({ovf0, ovf1, ovf2}), 32'b111);
        base = pulse_cnt;
        tx_dir = 1'b1;
        wait_pulses(base + DEPTH, DEPTH * (BUSY_TO + 3) + 10, "burst_drain");
        cyc(BUSY_TO + 6);
        chk("burst_no_fifth", 32'(pulse_cnt), 32'(base + DEPTH));
        chk("burst_empty", 32'(cnt1), 32'd0);

        // Random bytes against a randomly stalling transmitter
        resp_en = 1'b1;
        for (int b = 0; b < 8; b++) begin
            n = $urandom_range(1, DEPTH);
            base = pulse_cnt;
            for (int i = 0; i < n; i++) send(8'($urandom));
            wait_pulses(base + n, n * (BUSY_TO + 14) + 20, "rand_drain");
            cyc(BUSY_TO + 10);
        end
        resp_en = 1'b0;
        chk("overflow_sticky", 32'(ovf1), 32'd1);

        // Reset with three words queued
        tx_dir = 1'b0;
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        chk("pre_reset_count", 32'(cnt1), 32'd3);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_count", 32'(cnt1), 32'd0);
        chk("mid_rst_overflow", 32'(ovf1), 32'd0);
        chk("mid_rst_tx_enable", 32'(tx_en1), 32'd0);
        chk("mid_rst_tx_data", 32'(tx_data1), 32'd0);
        cyc(2);
        tx_dir = 1'b1;
        reset = 1'b0;
        base = pulse_cnt;
        cyc(30);
        chk("post_rst_no_pulse", 32'(pulse_cnt), 32'(base));
        chk("post_rst_low_rx_no_capture", 32'(cnt1), 32'd0);
        send(8'h5A);
        wait_pulses(base + 1, 10, "post_rst_echo");
        cyc(BUSY_TO + 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Transmitter model: after each pulse it usually goes busy for a few cycles, sometimes never.
    initial forever begin
        @(negedge sys_clk);
        if (resp_en && tx_en1 && $urandom_range(0, 3) != 0) begin
            repeat ($urandom_range(1, 4)) @(posedge sys_clk);
            #1 tx_resp = 1'b0;
            repeat ($urandom_range(1, 6)) @(posedge sys_clk);
            #1 tx_resp = 1'b1;
        end
    end

endmodule
